// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared types, defaults and helpers for the register file
// Purpose : inc_mode encoding, default special-register indices and flag mask,
//           and a helper that extracts one index field from a packed port vector.
// Ports   : none (package).
// Options : REGFILE_BYPASS_EN (used by cpu_regfile_gen, not here).
package cpu_regfile_pkg;

   typedef enum logic [1:0] {
      IncModeNone       = 2'd0,
      IncModeInc        = 2'd1,
      IncModeDec        = 2'd2,
      IncModeIncNoWrite = 2'd3
   } inc_mode_e;

   localparam int         DEF_FLAG_IDX  = 6;
   localparam int         DEF_PC_HI_IDX = 12;
   localparam logic [7:0] DEF_FLAG_MASK = 8'hF0;

   // Returns field 'port' of 'width' bits from a packed vector (LSB field = port 0).
   function automatic logic [31:0] unpack_idx(input logic [255:0] vec,
                                              input int port,
                                              input int width);
      logic [255:0] field_mask;
      logic [255:0] shifted;
      field_mask = (256'(1) << width) - 256'(1);
      shifted    = (vec >> (port * width)) & field_mask;
      return shifted[31:0];
   endfunction

endpackage

// File: rtl/cpu_regfile_gen_if.sv
// rtl/cpu_regfile_gen_if.sv - control/datapath bus of the register file
// Purpose : groups every non-clock signal of cpu_regfile_gen.
// Modports: master = cpu_control side (drives requests), slave = register file.
// Signals : stall, t_cycle, m_commit, rd_idx/rd_data, wr_en/wr_idx/wr_data,
//           inc_mode/inc_pair/inc_out, pc_load, flag_wr_en/flag_data, pc,
//           collision, collision_clr.
// Options : REGFILE_BYPASS_EN affects only the slave's read behaviour.
interface cpu_regfile_gen_if #(
   parameter int NUM_REGS = 14,
   parameter int DATA_W   = 8,
   parameter int NUM_READ = 2,
   parameter int T_PER_M  = 4
);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int TW    = $clog2(T_PER_M);

   logic                         stall;
   logic [TW-1:0]                t_cycle;
   logic                         m_commit;
   logic [NUM_READ*IDX_W-1:0]    rd_idx;
   logic [NUM_READ*DATA_W-1:0]   rd_data;
   logic                         wr_en;
   logic [IDX_W-1:0]             wr_idx;
   logic [DATA_W-1:0]            wr_data;
   logic [1:0]                   inc_mode;
   logic [IDX_W-2:0]             inc_pair;
   logic [2*DATA_W-1:0]          inc_out;
   logic                         pc_load;
   logic                         flag_wr_en;
   logic [DATA_W-1:0]            flag_data;
   logic [2*DATA_W-1:0]          pc;
   logic                         collision;
   logic                         collision_clr;

   modport master (
      output stall, rd_idx, wr_en, wr_idx, wr_data, inc_mode, inc_pair,
             pc_load, flag_wr_en, flag_data, collision_clr,
      input  t_cycle, m_commit, rd_data, inc_out, pc, collision
   );

   modport slave (
      input  stall, rd_idx, wr_en, wr_idx, wr_data, inc_mode, inc_pair,
             pc_load, flag_wr_en, flag_data, collision_clr,
      output t_cycle, m_commit, rd_data, inc_out, pc, collision
   );

endinterface

// File: rtl/cpu_tcycle_counter.sv
// rtl/cpu_tcycle_counter.sv - T-cycle phase counter with stall
// Purpose : counts 0..T_PER_M-1 and flags the commit phase.
// Ports   : clk, reset_n (async, active low), stall (hold),
//           t_cycle (current phase), m_commit (last phase and not stalled).
module cpu_tcycle_counter #(
   parameter  int T_PER_M = 4,
   localparam int TW      = $clog2(T_PER_M)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          stall,
   output logic [TW-1:0] t_cycle,
   output logic          m_commit
);
   localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

   logic [TW-1:0] t_q;
   logic [TW-1:0] t_d;

   always_comb begin
      t_d = t_q;
      if (!stall) begin
         t_d = (t_q == T_LAST) ? '0 : t_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) t_q <= '0;
      else          t_q <= t_d;
   end

   assign t_cycle  = t_q;
   assign m_commit = (t_q == T_LAST) && !stall;

endmodule

// File: rtl/cpu_regfile_gen.sv
// rtl/cpu_regfile_gen.sv - parametrised CPU register file with pair incrementer
// Purpose : NUM_REGS x DATA_W registers, NUM_READ combinational read ports,
//           16-bit pair inc/dec, PC pair, masked flags register, sticky
//           collision flag; all writes commit on the last T-cycle of an M-cycle.
// Ports   : clk, reset_n (async, active low), bus (cpu_regfile_gen_if.slave).
// Options : REGFILE_BYPASS_EN - reads on the commit phase return the value
//           being written this commit.
module cpu_regfile_gen
   import cpu_regfile_pkg::*;
#(
   parameter int                NUM_REGS  = 14,
   parameter int                DATA_W    = 8,
   parameter int                NUM_READ  = 2,
   parameter int                T_PER_M   = 4,
   parameter int                FLAG_IDX  = DEF_FLAG_IDX,
   parameter logic [DATA_W-1:0] FLAG_MASK = DATA_W'(DEF_FLAG_MASK),
   parameter int                PC_HI_IDX = DEF_PC_HI_IDX
) (
   input  logic               clk,
   input  logic               reset_n,
   cpu_regfile_gen_if.slave   bus
);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int NSLOT = 1 << IDX_W;
   localparam int PW    = 2 * DATA_W;

   localparam logic [IDX_W-1:0] PC_HI = IDX_W'(PC_HI_IDX);
   localparam logic [IDX_W-1:0] PC_LO = IDX_W'(PC_HI_IDX + 1);
   localparam logic [IDX_W-1:0] FLAG  = IDX_W'(FLAG_IDX);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic [DATA_W-1:0]        regs_x [NSLOT];   // index-space view, unused slots read 0
   logic                     collision_q;
   logic                     collision_d;
   logic                     m_commit;
   logic [NSLOT-1:0]         hit;
   logic [DATA_W-1:0]        wval [NSLOT];
   logic                     multi;
   inc_mode_e                mode;
   logic [IDX_W-1:0]         hi_idx;
   logic [IDX_W-1:0]         lo_idx;
   logic [PW-1:0]            inc_in;
   logic [PW-1:0]            inc_out;
   logic [NUM_READ*DATA_W-1:0] rd_data_w;

   cpu_tcycle_counter #(.T_PER_M(T_PER_M)) u_tcycle (
      .clk      (clk),
      .reset_n  (reset_n),
      .stall    (bus.stall),
      .t_cycle  (bus.t_cycle),
      .m_commit (m_commit)
   );
   assign bus.m_commit = m_commit;

   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      if (i < NUM_REGS) begin : g_real
         assign regs_x[i] = regs_q[i];
      end else begin : g_pad
         assign regs_x[i] = '0;
      end
   end

   assign mode   = inc_mode_e'(bus.inc_mode);
   assign hi_idx = {bus.inc_pair, 1'b0};
   assign lo_idx = {bus.inc_pair, 1'b1};
   assign inc_in = {regs_x[hi_idx], regs_x[lo_idx]};

   always_comb begin
      case (mode)
         IncModeNone: inc_out = inc_in;
         IncModeDec:  inc_out = inc_in - PW'(1);
         default:     inc_out = inc_in + PW'(1);
      endcase
   end
   assign bus.inc_out = inc_out;

   // Sources are merged lowest priority first so later ones overwrite; a
   // target already marked means two sources hit the same register.
   always_comb begin
      hit   = '0;
      multi = 1'b0;
      for (int i = 0; i < NSLOT; i++) wval[i] = '0;
      if (bus.wr_en) begin
         multi              = multi | hit[bus.wr_idx];
         hit[bus.wr_idx]    = 1'b1;
         wval[bus.wr_idx]   = bus.wr_data;
      end
      if (mode == IncModeInc || mode == IncModeDec) begin
         multi        = multi | hit[hi_idx];
         hit[hi_idx]  = 1'b1;
         wval[hi_idx] = inc_out[PW-1:DATA_W];
         multi        = multi | hit[lo_idx];
         hit[lo_idx]  = 1'b1;
         wval[lo_idx] = inc_out[DATA_W-1:0];
      end
      if (bus.pc_load) begin
         multi       = multi | hit[PC_HI];
         hit[PC_HI]  = 1'b1;
         wval[PC_HI] = inc_out[PW-1:DATA_W];
         multi       = multi | hit[PC_LO];
         hit[PC_LO]  = 1'b1;
         wval[PC_LO] = inc_out[DATA_W-1:0];
      end
      if (bus.flag_wr_en) begin
         multi      = multi | hit[FLAG];
         hit[FLAG]  = 1'b1;
         wval[FLAG] = bus.flag_data;
      end
      wval[FLAG] = wval[FLAG] & FLAG_MASK;
      // Writes to slots beyond the register array are dropped.
      for (int i = NUM_REGS; i < NSLOT; i++) hit[i] = 1'b0;
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = (m_commit && hit[i]) ? wval[i] : regs_q[i];
      end
      collision_d = collision_q;
      if (m_commit && multi) collision_d = 1'b1;
      if (bus.collision_clr) collision_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         collision_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         collision_q <= collision_d;
      end
   end

   always_comb begin
      logic [IDX_W-1:0]  ridx;
      logic [DATA_W-1:0] rval;
      rd_data_w = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         ridx = IDX_W'(unpack_idx(256'(bus.rd_idx), k, IDX_W));
         rval = regs_x[ridx];
`ifdef REGFILE_BYPASS_EN
         if (m_commit && hit[ridx]) rval = wval[ridx];
`endif
         rd_data_w[k*DATA_W +: DATA_W] = rval;
      end
   end

   assign bus.rd_data   = rd_data_w;
   assign bus.pc        = {regs_q[PC_HI_IDX], regs_q[PC_HI_IDX+1]};
   assign bus.collision = collision_q;

endmodule

// File: tb/tb_cpu_regfile_gen.sv
// tb/tb_cpu_regfile_gen.sv - directed self-checking bench for cpu_regfile_gen
module tb_cpu_regfile_gen;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   logic [7:0] v;

   cpu_regfile_gen_if #(.NUM_REGS(14), .DATA_W(8), .NUM_READ(2), .T_PER_M(4)) bus ();

   cpu_regfile_gen dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.stall         = 1'b0;
      bus.wr_en         = 1'b0;
      bus.wr_idx        = '0;
      bus.wr_data       = '0;
      bus.inc_mode      = 2'd0;
      bus.inc_pair      = '0;
      bus.pc_load       = 1'b0;
      bus.flag_wr_en    = 1'b0;
      bus.flag_data     = '0;
      bus.collision_clr = 1'b0;
   endtask

   task automatic peek(input int idx, output logic [7:0] val);
      bus.rd_idx[7:4] = idx[3:0];
      #1;
      val = bus.rd_data[15:8];
   endtask

   task automatic goto_phase(input int p);
      int n;
      n = 0;
      while (int'(bus.t_cycle) != p && n < 20) begin
         step();
         n++;
      end
      check("phase_reach", 32'(bus.t_cycle), 32'(p));
   endtask

   task automatic commit();
      goto_phase(3);
      step();
      idle();
   endtask

   task automatic wr_reg(input int idx, input logic [7:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_idx  = idx[3:0];
      bus.wr_data = data;
      commit();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle();
      bus.rd_idx = '0;
      reset_n    = 1'b0;
      #2;
      check("rst_t_cycle", 32'(bus.t_cycle), 0);
      check("rst_m_commit", 32'(bus.m_commit), 0);
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_collision", 32'(bus.collision), 0);
      #1 reset_n = 1'b1;

      // reset in the middle of an M-cycle
      wr_reg(3, 8'h55);
      step();
      step();
      check("mid_t_cycle", 32'(bus.t_cycle), 2);
      peek(3, v);
      check("mid_reg3", 32'(v), 32'h55);
      reset_n = 1'b0;
      #1;
      check("arst_t_cycle", 32'(bus.t_cycle), 0);
      check("arst_m_commit", 32'(bus.m_commit), 0);
      peek(3, v);
      check("arst_reg3", 32'(v), 0);
      #3 reset_n = 1'b1;
      step();
      check("rel1_t", 32'(bus.t_cycle), 1);
      check("rel1_mc", 32'(bus.m_commit), 0);
      step();
      check("rel2_t", 32'(bus.t_cycle), 2);
      check("rel2_mc", 32'(bus.m_commit), 0);
      step();
      check("rel3_t", 32'(bus.t_cycle), 3);
      check("rel3_mc", 32'(bus.m_commit), 1);

      // incrementer wrap and modes on pair 2 (regs 4,5)
      wr_reg(4, 8'hFF);
      wr_reg(5, 8'hFF);
      bus.inc_mode = 2'd1;
      bus.inc_pair = 3'd2;
      #1;
      check("inc_wrap_out", 32'(bus.inc_out), 32'h0000);
      commit();
      peek(4, v);
      check("inc_wrap_r4", 32'(v), 0);
      peek(5, v);
      check("inc_wrap_r5", 32'(v), 0);
      check("inc_no_coll", 32'(bus.collision), 0);
      bus.inc_mode = 2'd2;
      bus.inc_pair = 3'd2;
      #1;
      check("dec_wrap_out", 32'(bus.inc_out), 32'hFFFF);
      commit();
      peek(4, v);
      check("dec_wrap_r4", 32'(v), 32'hFF);
      peek(5, v);
      check("dec_wrap_r5", 32'(v), 32'hFF);
      bus.inc_mode = 2'd3;
      bus.inc_pair = 3'd2;
      #1;
      check("incnw_out", 32'(bus.inc_out), 32'h0000);
      commit();
      peek(4, v);
      check("incnw_r4", 32'(v), 32'hFF);
      peek(5, v);
      check("incnw_r5", 32'(v), 32'hFF);
      bus.inc_pair = 3'd2;
      #1;
      check("inc_pass_out", 32'(bus.inc_out), 32'hFFFF);
      idle();

      // flags priority, masking and collision
      bus.wr_en      = 1'b1;
      bus.wr_idx     = 4'd6;
      bus.wr_data    = 8'hAB;
      bus.flag_wr_en = 1'b1;
      bus.flag_data  = 8'h3F;
      commit();
      peek(6, v);
      check("prio_r6", 32'(v), 32'h30);
      check("prio_coll", 32'(bus.collision), 1);
      bus.collision_clr = 1'b1;
      step();
      bus.collision_clr = 1'b0;
      check("coll_clr", 32'(bus.collision), 0);
      wr_reg(6, 8'hAB);
      peek(6, v);
      check("wr_flag_mask", 32'(v), 32'hA0);
      check("wr_flag_nocoll", 32'(bus.collision), 0);
      bus.wr_en         = 1'b1;
      bus.wr_idx        = 4'd6;
      bus.wr_data       = 8'h12;
      bus.flag_wr_en    = 1'b1;
      bus.flag_data     = 8'h55;
      bus.collision_clr = 1'b1;
      commit();
      check("clr_beats_set", 32'(bus.collision), 0);
      peek(6, v);
      check("clr_set_r6", 32'(v), 32'h50);

      // pc_load beats wr port on the PC pair
      wr_reg(0, 8'h02);
      wr_reg(1, 8'h00);
      bus.inc_mode = 2'd3;
      bus.inc_pair = 3'd0;
      bus.pc_load  = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_idx   = 4'd12;
      bus.wr_data  = 8'h11;
      #1;
      check("pcl_inc_out", 32'(bus.inc_out), 32'h0201);
      commit();
      check("pcl_pc", 32'(bus.pc), 32'h0201);
      check("pcl_coll", 32'(bus.collision), 1);
      peek(0, v);
      check("pcl_r0", 32'(v), 32'h02);
      peek(1, v);
      check("pcl_r1", 32'(v), 32'h00);
      bus.collision_clr = 1'b1;
      step();
      bus.collision_clr = 1'b0;

      // stall on the commit phase
      goto_phase(3);
      bus.stall   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_idx  = 4'd0;
      bus.wr_data = 8'h7E;
      #1;
      check("stall_mc", 32'(bus.m_commit), 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_t", 32'(bus.t_cycle), 3);
         peek(0, v);
         check("stall_r0", 32'(v), 32'h02);
      end
      bus.stall = 1'b0;
      #1;
      check("unstall_mc", 32'(bus.m_commit), 1);
      step();
      check("unstall_t", 32'(bus.t_cycle), 0);
      peek(0, v);
      check("unstall_r0", 32'(v), 32'h7E);
      idle();

      // out-of-range read index
      bus.rd_idx[3:0] = 4'd15;
      #1;
      check("oor_read", 32'(bus.rd_data[7:0]), 0);

      // read during commit with a write to the same register
      goto_phase(3);
      bus.rd_idx[3:0] = 4'd1;
      bus.wr_en       = 1'b1;
      bus.wr_idx      = 4'd1;
      bus.wr_data     = 8'h9C;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_rd0", 32'(bus.rd_data[7:0]), 32'h9C);
`else
      check("bypass_rd0", 32'(bus.rd_data[7:0]), 32'h00);
`endif
      step();
      idle();
      check("post_commit_rd0", 32'(bus.rd_data[7:0]), 32'h9C);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
